// File: rtl/core_pkg.sv
// Shared micro-op types and widths for the issue path.
// Holds register/PC widths, ALU opcodes and the micro-op bundle.
package core_pkg;

   localparam int REG_AW = 3;
   localparam int PC_W   = 16;
   localparam int OP_W   = 5;

   localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
   localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
   localparam logic [OP_W-1:0] ALU_AND = 5'd2;
   localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
   localparam logic [OP_W-1:0] ALU_XOR = 5'd4;
   localparam logic [OP_W-1:0] ALU_SHL = 5'd5;
   localparam logic [OP_W-1:0] ALU_SHR = 5'd6;
   localparam logic [OP_W-1:0] ALU_CMP = 5'd7;
   localparam logic [OP_W-1:0] ALU_ADC = 5'd8;

   typedef struct packed {
      logic [REG_AW-1:0] a_adr;
      logic [REG_AW-1:0] b_adr;
      logic [PC_W-1:0]   pc;
      logic [REG_AW-1:0] d_adr;
      logic              d_wr;
      logic              sf_wr;
      logic              sf_rd;
      logic [OP_W-1:0]   op;
   } uop_t;

endpackage

// File: rtl/uop_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush, head data and count.
// Ports: push_i/pop_i/flush_i, wdata_i, rdata_o (head), count_o, empty_o, full_o.
module uop_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[head_q];

   // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) tail_d = tail_q + 1'b1;
         if (do_pop)  head_d = head_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !flush_i) begin
         mem_q[tail_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/issue_station.sv
// Issue stage: buffers decoded micro-ops, issues one per cycle to RF/ALU.
// Ports: id_* decoder side, r_* RF reads, ex_* ALU controls, alu_ready, flush, occupancy.
import core_pkg::*;

module issue_station #(
   parameter int DEPTH = 4,
   parameter int OPW   = OP_W,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [REG_AW-1:0]   id_a_adr,
   input  logic [REG_AW-1:0]   id_b_adr,
   input  logic [PC_W-1:0]     id_pc,
   input  logic [REG_AW-1:0]   id_d_adr,
   input  logic                id_d_wr,
   input  logic                id_sf_wr,
   input  logic                id_sf_rd,
   input  logic [OPW-1:0]      id_op,
   output logic [REG_AW-1:0]   r_a_addr,
   output logic [REG_AW-1:0]   r_b_addr,
   output logic [PC_W-1:0]     r_pc,
   output logic                ex_valid,
   output logic [OPW-1:0]      ex_op,
   output logic [REG_AW-1:0]   ex_d_adr,
   output logic                ex_d_wr,
   output logic                ex_sf_wr,
   input  logic                alu_ready,
   input  logic                flush,
   output logic [CW-1:0]       occupancy
);

   uop_t          id_uop;
   uop_t          head;
   logic [$bits(uop_t)-1:0] head_raw;
   logic          empty;
   logic          full;
   logic          push;
   logic          hazard;
   logic          issue;

   logic              ex_valid_q, ex_valid_d;
   logic [OPW-1:0]    ex_op_q, ex_op_d;
   logic [REG_AW-1:0] ex_d_adr_q, ex_d_adr_d;
   logic              ex_d_wr_q, ex_d_wr_d;
   logic              ex_sf_wr_q, ex_sf_wr_d;

   assign id_uop = '{
      a_adr: id_a_adr,
      b_adr: id_b_adr,
      pc:    id_pc,
      d_adr: id_d_adr,
      d_wr:  id_d_wr,
      sf_wr: id_sf_wr,
      sf_rd: id_sf_rd,
      op:    OP_W'(id_op)
   };

   // Readiness comes from the registered count only.
   assign id_ready = ~full & ~flush;
   assign push     = id_valid & id_ready;

   uop_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(uop_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (issue),
      .flush_i (flush),
      .wdata_i (id_uop),
      .rdata_o (head_raw),
      .count_o (occupancy),
      .empty_o (empty),
      .full_o  (full)
   );

   assign head = uop_t'(head_raw);

   // A flag reader waits while a flag writer sits in the ex register.
   assign hazard = head.sf_rd & ex_valid_q & ex_sf_wr_q;
   assign issue  = ~empty & alu_ready & ~hazard & ~flush;

   assign r_a_addr = empty ? '0 : head.a_adr;
   assign r_b_addr = empty ? '0 : head.b_adr;
   assign r_pc     = empty ? '0 : head.pc;

   // Non-issue cycles zero every control so write enables never go stale.
   always_comb begin
      ex_valid_d = 1'b0;
      ex_op_d    = '0;
      ex_d_adr_d = '0;
      ex_d_wr_d  = 1'b0;
      ex_sf_wr_d = 1'b0;
      if (issue) begin
         ex_valid_d = 1'b1;
         ex_op_d    = OPW'(head.op);
         ex_d_adr_d = head.d_adr;
         ex_d_wr_d  = head.d_wr;
         ex_sf_wr_d = head.sf_wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= '0;
         ex_d_adr_q <= '0;
         ex_d_wr_q  <= 1'b0;
         ex_sf_wr_q <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_op_q    <= ex_op_d;
         ex_d_adr_q <= ex_d_adr_d;
         ex_d_wr_q  <= ex_d_wr_d;
         ex_sf_wr_q <= ex_sf_wr_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_op    = ex_op_q;
   assign ex_d_adr = ex_d_adr_q;
   assign ex_d_wr  = ex_d_wr_q;
   assign ex_sf_wr = ex_sf_wr_q;

endmodule

// File: tb/tb_issue_station.sv
// Directed bench for issue_station with immediate-assertion checks.
// Drives the decoder/ALU side, checks RF addresses, ex controls and occupancy.
module tb_issue_station;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic        id_ready;
   logic [2:0]  id_a_adr;
   logic [2:0]  id_b_adr;
   logic [15:0] id_pc;
   logic [2:0]  id_d_adr;
   logic        id_d_wr;
   logic        id_sf_wr;
   logic        id_sf_rd;
   logic [4:0]  id_op;
   logic [2:0]  r_a_addr;
   logic [2:0]  r_b_addr;
   logic [15:0] r_pc;
   logic        ex_valid;
   logic [4:0]  ex_op;
   logic [2:0]  ex_d_adr;
   logic        ex_d_wr;
   logic        ex_sf_wr;
   logic        alu_ready;
   logic        flush;
   logic [2:0]  occupancy;

   int checks;
   int errors;

   issue_station #(.DEPTH(4), .OPW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .id_a_adr  (id_a_adr),
      .id_b_adr  (id_b_adr),
      .id_pc     (id_pc),
      .id_d_adr  (id_d_adr),
      .id_d_wr   (id_d_wr),
      .id_sf_wr  (id_sf_wr),
      .id_sf_rd  (id_sf_rd),
      .id_op     (id_op),
      .r_a_addr  (r_a_addr),
      .r_b_addr  (r_b_addr),
      .r_pc      (r_pc),
      .ex_valid  (ex_valid),
      .ex_op     (ex_op),
      .ex_d_adr  (ex_d_adr),
      .ex_d_wr   (ex_d_wr),
      .ex_sf_wr  (ex_sf_wr),
      .alu_ready (alu_ready),
      .flush     (flush),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [2:0] a, input logic [2:0] b,
                         input logic [15:0] pc, input logic [2:0] d,
                         input logic dw, input logic sw, input logic sr);
      id_a_adr = a;
      id_b_adr = b;
      id_pc    = pc;
      id_d_adr = d;
      id_d_wr  = dw;
      id_sf_wr = sw;
      id_sf_rd = sr;
      id_op    = 5'd3;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      id_valid  = 1'b0;
      alu_ready = 1'b0;
      flush     = 1'b0;
      set_op(0, 0, 16'h0, 0, 0, 0, 0);
      #2;
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_exv", 32'(ex_valid), 0);
      chk("rst_rpc", 32'(r_pc), 0);
      chk("rst_ra", 32'(r_a_addr), 0);
      chk("rst_exdwr", 32'(ex_d_wr), 0);
      #10 rst_n = 1'b1;

      // single op, two-cycle path to ex
      alu_ready = 1'b1;
      id_valid  = 1'b1;
      set_op(1, 2, 16'h1234, 5, 1, 0, 0);
      chk("t1_rdy", 32'(id_ready), 1);
      tick();
      id_valid = 1'b0;
      chk("t1_ra", 32'(r_a_addr), 1);
      chk("t1_rb", 32'(r_b_addr), 2);
      chk("t1_rpc", 32'(r_pc), 32'h1234);
      chk("t1_occ1", 32'(occupancy), 1);
      chk("t1_exv0", 32'(ex_valid), 0);
      tick();
      chk("t1_exv", 32'(ex_valid), 1);
      chk("t1_exd", 32'(ex_d_adr), 5);
      chk("t1_exdwr", 32'(ex_d_wr), 1);
      chk("t1_exop", 32'(ex_op), 3);
      chk("t1_occ0", 32'(occupancy), 0);
      chk("t1_rpc0", 32'(r_pc), 0);
      tick();
      chk("t1_exv_off", 32'(ex_valid), 0);
      chk("t1_exdwr_off", 32'(ex_d_wr), 0);

      // fill under backpressure, then drain in order
      alu_ready = 1'b0;
      id_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_op(3'(i), 3'(i), 16'h10 + 16'(i), 3'(i + 1), 1, 0, 0);
         chk("t2_rdy", 32'(id_ready), 1);
         tick();
      end
      chk("t2_occ4", 32'(occupancy), 4);
      chk("t2_full", 32'(id_ready), 0);
      set_op(4, 4, 16'h14, 5, 1, 0, 0);
      tick();
      chk("t2_hold", 32'(occupancy), 4);
      chk("t2_head", 32'(r_pc), 32'h10);
      chk("t2_noex", 32'(ex_valid), 0);
      alu_ready = 1'b1;
      tick();
      chk("t2_exd1", 32'(ex_d_adr), 1);
      chk("t2_exv1", 32'(ex_valid), 1);
      chk("t2_rpc1", 32'(r_pc), 32'h11);
      chk("t2_occA", 32'(occupancy), 3);
      chk("t2_rdyA", 32'(id_ready), 1);
      tick();
      id_valid = 1'b0;
      chk("t2_exd2", 32'(ex_d_adr), 2);
      chk("t2_rpc2", 32'(r_pc), 32'h12);
      chk("t2_occB", 32'(occupancy), 3);
      tick();
      chk("t2_exd3", 32'(ex_d_adr), 3);
      chk("t2_occC", 32'(occupancy), 2);
      tick();
      chk("t2_exd4", 32'(ex_d_adr), 4);
      chk("t2_rpc4", 32'(r_pc), 32'h14);
      chk("t2_occD", 32'(occupancy), 1);
      tick();
      chk("t2_exd5", 32'(ex_d_adr), 5);
      chk("t2_exv5", 32'(ex_valid), 1);
      chk("t2_occE", 32'(occupancy), 0);
      tick();
      chk("t2_exvF", 32'(ex_valid), 0);

      // flag writer then reader: one bubble
      id_valid = 1'b1;
      set_op(1, 1, 16'h20, 1, 1, 1, 0);
      tick();
      set_op(2, 2, 16'h21, 2, 1, 0, 1);
      tick();
      id_valid = 1'b0;
      chk("t3_exv1", 32'(ex_valid), 1);
      chk("t3_sfw1", 32'(ex_sf_wr), 1);
      chk("t3_occ", 32'(occupancy), 1);
      tick();
      chk("t3_bub", 32'(ex_valid), 0);
      chk("t3_sfw0", 32'(ex_sf_wr), 0);
      chk("t3_wait", 32'(occupancy), 1);
      tick();
      chk("t3_exv2", 32'(ex_valid), 1);
      chk("t3_sfw2", 32'(ex_sf_wr), 0);
      chk("t3_exd2", 32'(ex_d_adr), 2);
      tick();

      // steady push/pop at occupancy 2, pointers wrap
      alu_ready = 1'b0;
      id_valid  = 1'b1;
      set_op(0, 0, 16'h30, 1, 1, 0, 0);
      tick();
      set_op(0, 0, 16'h31, 1, 1, 0, 0);
      tick();
      alu_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_op(0, 0, 16'h32 + 16'(k), 1, 1, 0, 0);
         chk("t4_occ", 32'(occupancy), 2);
         chk("t4_pc", 32'(r_pc), 32'h30 + 32'(k));
         tick();
      end
      id_valid = 1'b0;
      chk("t4_pc6", 32'(r_pc), 32'h36);
      tick();
      chk("t4_pc7", 32'(r_pc), 32'h37);
      tick();
      chk("t4_empty", 32'(occupancy), 0);
      tick();

      // flush with 3 buffered and ex busy
      alu_ready = 1'b0;
      id_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_op(0, 0, 16'h40 + 16'(i), 7, 1, 0, 0);
         tick();
      end
      id_valid  = 1'b0;
      alu_ready = 1'b1;
      tick();
      chk("t5_occ3", 32'(occupancy), 3);
      chk("t5_exv", 32'(ex_valid), 1);
      flush    = 1'b1;
      id_valid = 1'b1;
      set_op(0, 0, 16'h50, 6, 1, 0, 0);
      #1;
      chk("t5_rdy", 32'(id_ready), 0);
      tick();
      flush    = 1'b0;
      id_valid = 1'b0;
      chk("t5_occ0", 32'(occupancy), 0);
      chk("t5_exv0", 32'(ex_valid), 0);
      chk("t5_dwr0", 32'(ex_d_wr), 0);
      chk("t5_rpc0", 32'(r_pc), 0);
      tick();
      chk("t5_nopush", 32'(occupancy), 0);
      chk("t5_noex", 32'(ex_valid), 0);

      // async reset between edges with full FIFO
      alu_ready = 1'b0;
      id_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_op(0, 0, 16'h60 + 16'(i), 3, 1, 0, 0);
         tick();
      end
      id_valid = 1'b0;
      chk("t6_full", 32'(occupancy), 4);
      alu_ready = 1'b1;
      tick();
      chk("t6_exv", 32'(ex_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_occ", 32'(occupancy), 0);
      chk("t6_exv0", 32'(ex_valid), 0);
      chk("t6_rpc", 32'(r_pc), 0);
      #3 rst_n = 1'b1;
      tick();
      chk("t6_after", 32'(occupancy), 0);
      chk("t6_exafter", 32'(ex_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
